// File: rtl/theia_wb_interconnect.sv
// N-core Wishbone master interconnect: round-robin arbitration with burst-limit
// preemption, owner-muxed external bus, stall timeout abort and DONE aggregation.
module theia_wb_interconnect #(
    parameter int NCORES    = 4,
    parameter int WB_WIDTH  = 32,
    parameter int TAG_W     = 2,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                         CLK_I,
    input  logic                         RST_I,
    input  logic [NCORES-1:0]            CORE_CYC_I,
    input  logic [NCORES-1:0]            CORE_STB_I,
    input  logic [NCORES-1:0]            CORE_WE_I,
    input  logic [NCORES*WB_WIDTH-1:0]   CORE_ADR_I,
    input  logic [NCORES*WB_WIDTH-1:0]   CORE_DAT_I,
    input  logic [NCORES*TAG_W-1:0]      CORE_TGA_I,
    output logic [NCORES-1:0]            CORE_GNT_O,
    output logic [NCORES-1:0]            CORE_ACK_O,
    output logic [NCORES-1:0]            CORE_ERR_O,
    input  logic [NCORES-1:0]            CORE_DONE_I,
    input  logic [NCORES-1:0]            CORE_EN_I,
    output logic                         CYC_O,
    output logic                         STB_O,
    output logic                         WE_O,
    output logic [WB_WIDTH-1:0]          ADR_O,
    output logic [WB_WIDTH-1:0]          DAT_O,
    output logic [TAG_W-1:0]             TGA_O,
    input  logic                         ACK_I,
    output logic [$clog2(NCORES)-1:0]    OWNER_O,
    output logic                         DONE_O
);

    localparam int OW = $clog2(NCORES);
    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_LAST = BW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
    localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_YIELD = 2'd2;

    logic [1:0]        state_reg;
    logic [OW-1:0]     owner_reg;
    logic [NCORES-1:0] gnt_reg;
    logic [NCORES-1:0] err_reg;
    logic [NCORES-1:0] lock_reg;
    logic [BW-1:0]     burst_reg;
    logic [TW-1:0]     tmo_reg;
    logic              done_reg;

    logic [NCORES-1:0] req;
    logic              busy;
    logic              own_stb;
    logic              ack_hit;
    logic              owner_off;
    logic              other_req;
    logic              tmo_fire;
    logic              burst_full;
    logic              rr_found;
    logic [OW-1:0]     rr_pick;
    logic [OW-1:0]     rr_cand;

    assign req       = CORE_CYC_I & CORE_EN_I & ~lock_reg;
    assign busy      = (state_reg == ST_BUSY);
    assign own_stb   = CORE_STB_I[owner_reg];
    assign ack_hit   = busy & own_stb & ACK_I;
    assign owner_off = ~CORE_CYC_I[owner_reg] | ~CORE_EN_I[owner_reg];
    assign other_req = |(req & ~gnt_reg);

    // An ACK in the final stall cycle wins over the abort.
    assign tmo_fire   = (TIMEOUT > 0) && own_stb && !ACK_I && (tmo_reg == TMO_LAST);
    assign burst_full = (MAX_BURST > 0) &&
                        ((burst_reg == BURST_MAX) || (ack_hit && (burst_reg == BURST_LAST)));

    // Round-robin search starting just after the current/last owner.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_cand  = '0;
        for (int i = 1; i <= NCORES; i++) begin
            rr_cand = OW'((int'(owner_reg) + i) % NCORES);
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    assign CYC_O      = busy;
    assign STB_O      = busy & own_stb;
    assign WE_O       = busy & CORE_WE_I[owner_reg];
    assign ADR_O      = busy ? CORE_ADR_I[int'(owner_reg)*WB_WIDTH +: WB_WIDTH] : '0;
    assign DAT_O      = busy ? CORE_DAT_I[int'(owner_reg)*WB_WIDTH +: WB_WIDTH] : '0;
    assign TGA_O      = busy ? CORE_TGA_I[int'(owner_reg)*TAG_W +: TAG_W] : '0;
    assign CORE_GNT_O = gnt_reg;
    assign CORE_ERR_O = err_reg;
    assign OWNER_O    = owner_reg;
    assign DONE_O     = done_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NCORES; gi++) begin : g_ack
            assign CORE_ACK_O[gi] = busy & ACK_I & (owner_reg == OW'(gi));
        end
    endgenerate

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_reg <= ST_IDLE;
            owner_reg <= OW'(NCORES - 1);
            gnt_reg   <= '0;
            err_reg   <= '0;
            lock_reg  <= '0;
            burst_reg <= '0;
            tmo_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            err_reg  <= '0;
            done_reg <= &(CORE_DONE_I | ~CORE_EN_I);
            lock_reg <= lock_reg & CORE_CYC_I;
            case (state_reg)
                ST_IDLE: begin
                    if (rr_found) begin
                        owner_reg <= rr_pick;
                        gnt_reg   <= {{(NCORES-1){1'b0}}, 1'b1} << rr_pick;
                        burst_reg <= '0;
                        tmo_reg   <= '0;
                        state_reg <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (owner_off) begin
                        gnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end else if (tmo_fire) begin
                        err_reg   <= gnt_reg;
                        lock_reg  <= (lock_reg & CORE_CYC_I) | gnt_reg;
                        gnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end else if (burst_full && other_req) begin
                        gnt_reg   <= '0;
                        state_reg <= ST_YIELD;
                    end else begin
                        // Saturate so a lone owner keeps streaming past the limit.
                        if (ack_hit && (burst_reg != BURST_MAX || MAX_BURST == 0))
                            burst_reg <= burst_reg + BW'(1);
                        if (TIMEOUT > 0 && own_stb && !ACK_I)
                            tmo_reg <= tmo_reg + TW'(1);
                        else
                            tmo_reg <= '0;
                    end
                end
                ST_YIELD: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    gnt_reg   <= '0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_theia_wb_interconnect.sv
// Directed self-checking bench for theia_wb_interconnect (4 cores, burst 4, timeout 8).
module tb_theia_wb_interconnect;

    localparam int NC = 4;
    localparam int W  = 32;
    localparam int TW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NC-1:0]   cyc, stb, we, done, en;
    logic [NC*W-1:0] adr, dat;
    logic [NC*TW-1:0] tga;
    logic [NC-1:0]   gnt, cack, cerr;
    logic            cyc_o, stb_o, we_o, ack, done_o;
    logic [W-1:0]    adr_o, dat_o;
    logic [TW-1:0]   tga_o;
    logic [1:0]      owner;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    theia_wb_interconnect #(
        .NCORES(NC), .WB_WIDTH(W), .TAG_W(TW), .MAX_BURST(4), .TIMEOUT(8)
    ) dut (
        .CLK_I(clk), .RST_I(rst_n),
        .CORE_CYC_I(cyc), .CORE_STB_I(stb), .CORE_WE_I(we),
        .CORE_ADR_I(adr), .CORE_DAT_I(dat), .CORE_TGA_I(tga),
        .CORE_GNT_O(gnt), .CORE_ACK_O(cack), .CORE_ERR_O(cerr),
        .CORE_DONE_I(done), .CORE_EN_I(en),
        .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o),
        .ADR_O(adr_o), .DAT_O(dat_o), .TGA_O(tga_o),
        .ACK_I(ack), .OWNER_O(owner), .DONE_O(done_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc = '0; stb = '0; we = '0; ack = 1'b0;
        done = '0; en = 4'hF;
        adr = '0; dat = '0; tga = '0;
        tick();
        rst_n = 1'b1;
    endtask

    // Serve one ACK for core k, drop CYC, verify the dead cycle, re-request.
    task automatic serve(input int k);
        check("rr_gnt", 64'(gnt), 64'(1) << k);
        check("rr_cyc", 64'(cyc_o), 64'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0;
        tick();
        check("rr_dead", {cyc_o, gnt}, 64'd0);
        cyc[k] = 1'b1; stb[k] = 1'b1;
        tick();
        $display("rr: core %0d served", k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = '0; stb = '0; we = '0; ack = 1'b0; done = '0; en = 4'hF;
        adr = '0; dat = '0; tga = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_cyc", 64'(cyc_o), 64'd0);
        check("rst_owner", 64'(owner), 64'd3);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_err", 64'(cerr), 64'd0);
        $display("reset state checked");

        // Single request from core 2
        do_reset();
        adr = {32'h0000_0DDD, 32'h0000_0100, 32'h0000_0BBB, 32'h0000_0AAA};
        dat = {32'h1, 32'hCAFE_F00D, 32'h2, 32'h3};
        tga = 8'b01_10_11_01;
        we[2] = 1'b1; cyc[2] = 1'b1; stb[2] = 1'b1;
        #1 check("single_pre_gnt", 64'(gnt), 64'd0);
        tick();
        check("single_gnt", 64'(gnt), 64'h4);
        check("single_owner", 64'(owner), 64'd2);
        check("single_bus", {cyc_o, stb_o, we_o}, 64'b111);
        check("single_adr", 64'(adr_o), 64'h100);
        check("single_dat", 64'(dat_o), 64'hCAFE_F00D);
        check("single_tga", 64'(tga_o), 64'd2);
        ack = 1'b1;
        #1 check("single_ack_route", 64'(cack), 64'h4);
        tick();
        ack = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
        tick();
        check("single_release", {cyc_o, gnt}, 64'd0);
        check("single_idle_adr", 64'(adr_o), 64'd0);
        ack = 1'b1;
        #1 check("idle_ack_blocked", 64'(cack), 64'd0);
        ack = 1'b0;
        $display("single request transaction done");

        // Round robin among cores 0, 1, 3
        do_reset();
        cyc = 4'b1011; stb = 4'b1011;
        tick();
        serve(0);
        serve(1);
        serve(3);
        serve(0);
        cyc = '0; stb = '0;
        tick(); tick();

        // Preemption after 4 ACKs with core 1 waiting
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        tick();
        check("pre_gnt0", 64'(gnt), 64'h1);
        ack = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("pre_hold", {cyc_o, gnt}, {1'b1, 4'h1});
        end
        tick();
        check("pre_yield", {cyc_o, gnt}, 64'd0);
        check("pre_yield_ack", 64'(cack), 64'd0);
        ack = 1'b0;
        tick();
        check("pre_idle", {cyc_o, gnt}, 64'd0);
        tick();
        check("pre_gnt1", 64'(gnt), 64'h2);
        $display("preemption transaction done");

        // Lone owner keeps the bus past the burst limit
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        tick();
        ack = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("sat_hold", {cyc_o, gnt}, {1'b1, 4'h1});
        end
        ack = 1'b0; cyc[1] = 1'b1; stb[1] = 1'b1;
        tick();
        check("sat_late_yield", {cyc_o, gnt}, 64'd0);
        tick(); tick();
        check("sat_gnt1", 64'(gnt), 64'h2);
        $display("burst saturation transaction done");

        // Timeout abort of core 3, core 0 pending
        do_reset();
        cyc[3] = 1'b1; stb[3] = 1'b1;
        tick();
        check("tmo_gnt3", 64'(gnt), 64'h8);
        cyc[0] = 1'b1; stb[0] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("tmo_stall", {cerr, cyc_o}, {4'h0, 1'b1});
        end
        tick();
        check("tmo_err", 64'(cerr), 64'h8);
        check("tmo_drop", {cyc_o, gnt}, 64'd0);
        tick();
        check("tmo_err_pulse", 64'(cerr), 64'h0);
        check("tmo_gnt0", 64'(gnt), 64'h1);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        tick();
        tick();
        check("tmo_locked_a", 64'(gnt), 64'h0);
        tick();
        check("tmo_locked_b", 64'(gnt), 64'h0);
        cyc[3] = 1'b0;
        tick();
        cyc[3] = 1'b1;
        tick();
        check("tmo_regrant3", 64'(gnt), 64'h8);
        for (int i = 1; i <= 7; i++) tick();
        ack = 1'b1;
        tick();
        check("tmo_ack_wins", {cerr, cyc_o, gnt}, {4'h0, 1'b1, 4'h8});
        ack = 1'b0; cyc[3] = 1'b0; stb[3] = 1'b0;
        tick(); tick();
        $display("timeout transaction done");

        // Enable and done aggregation
        do_reset();
        en = 4'b0101; done = 4'b0001;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        tick(); tick();
        check("done_low", 64'(done_o), 64'd0);
        check("dis_no_gnt_a", 64'(gnt), 64'd0);
        done[2] = 1'b1;
        #1 check("done_lag", 64'(done_o), 64'd0);
        tick();
        check("done_high", 64'(done_o), 64'd1);
        check("dis_no_gnt_b", 64'(gnt), 64'd0);
        $display("enable/done transaction done");

        // Asynchronous reset mid-burst
        do_reset();
        adr[31:0] = 32'h1234;
        cyc[0] = 1'b1; stb[0] = 1'b1;
        tick();
        ack = 1'b1;
        tick(); tick();
        check("ar_busy", {cyc_o, adr_o}, {1'b1, 32'h1234});
        #2 rst_n = 1'b0;
        #1;
        check("ar_bus", {cyc_o, stb_o, we_o}, 64'd0);
        check("ar_adr", 64'(adr_o), 64'd0);
        check("ar_gnt", 64'(gnt), 64'd0);
        check("ar_ack", 64'(cack), 64'd0);
        check("ar_owner", 64'(owner), 64'd3);
        ack = 1'b0;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_first_core0", 64'(gnt), 64'h1);
        $display("async reset transaction done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
